// File: rtl/debug_cmd_ctrl_pkg.sv
// Shared constants, state encoding and opcode decode for the debug command front end.
// Build option: DBG_CMD_CHECKSUM_EN adds an XOR checksum byte to every command and response frame.
package debug_cmd_ctrl_pkg;

    localparam int DEBUG_WIDTH = 3;

    localparam logic [DEBUG_WIDTH-1:0] DEBUG_IDLE  = 3'd0;
    localparam logic [DEBUG_WIDTH-1:0] DEBUG_PCRD  = 3'd1;
    localparam logic [DEBUG_WIDTH-1:0] DEBUG_ICRD  = 3'd2;
    localparam logic [DEBUG_WIDTH-1:0] DEBUG_ICWR  = 3'd3;
    localparam logic [DEBUG_WIDTH-1:0] DEBUG_REGRD = 3'd4;
    localparam logic [DEBUG_WIDTH-1:0] DEBUG_DCRD  = 3'd5;

    localparam logic [7:0] DBG_OPC_PCRD  = 8'h01;
    localparam logic [7:0] DBG_OPC_ICRD  = 8'h02;
    localparam logic [7:0] DBG_OPC_ICWR  = 8'h03;
    localparam logic [7:0] DBG_OPC_REGRD = 8'h04;
    localparam logic [7:0] DBG_OPC_DCRD  = 8'h05;

    localparam logic [7:0] DBG_ACK = 8'hA5;
    localparam logic [7:0] DBG_ERR = 8'hEE;

`ifdef DBG_CMD_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CHK,
        ST_EXEC,
        ST_SETTLE,
        ST_RESP
    } state_t;

    function automatic logic [DEBUG_WIDTH-1:0] opc_to_code(input logic [7:0] opc);
        case (opc)
            DBG_OPC_PCRD:  return DEBUG_PCRD;
            DBG_OPC_ICRD:  return DEBUG_ICRD;
            DBG_OPC_ICWR:  return DEBUG_ICWR;
            DBG_OPC_REGRD: return DEBUG_REGRD;
            DBG_OPC_DCRD:  return DEBUG_DCRD;
            default:       return DEBUG_IDLE;
        endcase
    endfunction

    function automatic logic opc_known(input logic [7:0] opc);
        return opc_to_code(opc) != DEBUG_IDLE;
    endfunction

endpackage

// File: rtl/debug_cmd_ctrl_rsp_ser.sv
// Byte serializer for responses: emits 1 or 4 little-endian bytes of a word over valid/ready,
// followed by an XOR byte when DBG_CMD_CHECKSUM_EN is defined.
module dbg_rsp_ser
    import debug_cmd_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        multi,
    input  logic        rsp_ready,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        done
);

    logic [23:0] word_reg;
    logic [2:0]  cnt_reg;
    logic [7:0]  chk_reg;
    logic [7:0]  data_reg;
    logic        valid_reg;
    logic        fire;

    assign fire      = valid_reg & rsp_ready;
    assign done      = fire && (cnt_reg == 3'd0);
    assign rsp_valid = valid_reg;
    assign rsp_data  = data_reg;

    // cnt_reg counts bytes still to follow the one currently presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_reg  <= '0;
            cnt_reg   <= '0;
            chk_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            data_reg  <= word[7:0];
            word_reg  <= word[31:8];
            chk_reg   <= word[7:0];
            valid_reg <= 1'b1;
            cnt_reg   <= (multi ? 3'd3 : 3'd0) + (CHK_EN ? 3'd1 : 3'd0);
        end else if (fire) begin
            if (cnt_reg == 3'd0) begin
                valid_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg - 3'd1;
                if (CHK_EN && cnt_reg == 3'd1) begin
                    data_reg <= chk_reg;
                end else begin
                    data_reg <= word_reg[7:0];
                    word_reg <= {8'h00, word_reg[23:8]};
                    chk_reg  <= chk_reg ^ word_reg[7:0];
                end
            end
        end
    end

endmodule

// File: rtl/debug_cmd_ctrl.sv
// Host-side debug command front end: assembles byte-serial commands, drives io_control for a
// fixed hold window and returns the result bytes. DBG_CMD_CHECKSUM_EN enables XOR-checked frames.
module debug_cmd_ctrl
    import debug_cmd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int IADDR_WIDTH = 12,
    parameter int DADDR_WIDTH = 12,
    parameter int RADDR_WIDTH = 5,
    parameter int PC_WIDTH    = 12,
    parameter int HOLD_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   host_valid_i,
    input  logic [7:0]             host_data_i,
    output logic                   host_ready_o,
    output logic                   rsp_valid_o,
    output logic [7:0]             rsp_data_o,
    input  logic                   rsp_ready_i,
    output logic [DEBUG_WIDTH-1:0] debug_o,
    output logic [IADDR_WIDTH-1:0] icache_addr_o,
    output logic [DATA_WIDTH-1:0]  icache_wdata_o,
    output logic [RADDR_WIDTH-1:0] reg_raddr_o,
    output logic [DADDR_WIDTH-1:0] dcache_raddr_o,
    input  logic [PC_WIDTH-1:0]    pc_i,
    input  logic [DATA_WIDTH-1:0]  icache_rdata_i,
    input  logic [DATA_WIDTH-1:0]  reg_rdata_i,
    input  logic [DATA_WIDTH-1:0]  dcache_rdata_i
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    state_t                state_reg, state_next;
    logic [1:0]            byte_cnt_reg, byte_cnt_next;
    logic [7:0]            opc_reg, opc_next;
    logic [15:0]           addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [7:0]            chk_reg, chk_next;
    logic [HOLD_W-1:0]     hold_reg, hold_next;
    logic                  ready_reg;
    logic                  accept;
    logic                  exec_enter;
    logic                  ser_load, ser_multi, ser_done;
    logic [31:0]           ser_word;

    assign accept       = host_valid_i & ready_reg;
    assign host_ready_o = ready_reg;
    assign debug_o      = (state_reg == ST_EXEC) ? opc_to_code(opc_reg) : DEBUG_IDLE;

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        opc_next      = opc_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        chk_next      = chk_reg;
        hold_next     = hold_reg;
        exec_enter    = 1'b0;
        ser_load      = 1'b0;
        ser_multi     = 1'b0;
        ser_word      = {24'h0, DBG_ERR};
        case (state_reg)
            ST_IDLE: if (accept) begin
                opc_next      = host_data_i;
                chk_next      = host_data_i;
                byte_cnt_next = 2'd0;
                state_next    = ST_HDR;
            end
            ST_HDR: if (accept) begin
                chk_next = chk_reg ^ host_data_i;
                if (byte_cnt_reg == 2'd0) begin
                    addr_next[7:0] = host_data_i;
                    byte_cnt_next  = 2'd1;
                end else begin
                    addr_next[15:8] = host_data_i;
                    byte_cnt_next   = 2'd0;
                    if (opc_reg == DBG_OPC_ICWR) begin
                        state_next = ST_DATA;
                    end else if (CHK_EN) begin
                        state_next = ST_CHK;
                    end else if (opc_known(opc_reg)) begin
                        state_next = ST_EXEC;
                        exec_enter = 1'b1;
                    end else begin
                        state_next = ST_RESP;
                        ser_load   = 1'b1;
                    end
                end
            end
            ST_DATA: if (accept) begin
                chk_next = chk_reg ^ host_data_i;
                wdata_next[{byte_cnt_reg, 3'b000} +: 8] = host_data_i;
                byte_cnt_next = byte_cnt_reg + 2'd1;
                if (byte_cnt_reg == 2'd3) begin
                    if (CHK_EN) begin
                        state_next = ST_CHK;
                    end else begin
                        state_next = ST_EXEC;
                        exec_enter = 1'b1;
                    end
                end
            end
            ST_CHK: if (accept) begin
                if (host_data_i == chk_reg && opc_known(opc_reg)) begin
                    state_next = ST_EXEC;
                    exec_enter = 1'b1;
                end else begin
                    state_next = ST_RESP;
                    ser_load   = 1'b1;
                end
            end
            ST_EXEC: begin
                if (hold_reg == '0) state_next = ST_SETTLE;
                else                hold_next  = hold_reg - 1'b1;
            end
            ST_SETTLE: begin
                // io_control result registers are settled by now; capture straight into the serializer.
                ser_load   = 1'b1;
                ser_multi  = 1'b1;
                state_next = ST_RESP;
                case (opc_reg)
                    DBG_OPC_PCRD:  ser_word = 32'(pc_i);
                    DBG_OPC_ICRD:  ser_word = icache_rdata_i;
                    DBG_OPC_REGRD: ser_word = reg_rdata_i;
                    DBG_OPC_DCRD:  ser_word = dcache_rdata_i;
                    default: begin
                        ser_word  = {24'h0, DBG_ACK};
                        ser_multi = 1'b0;
                    end
                endcase
            end
            ST_RESP: if (ser_done) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (exec_enter) hold_next = HOLD_W'(HOLD_CYCLES - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            byte_cnt_reg   <= '0;
            opc_reg        <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            chk_reg        <= '0;
            hold_reg       <= '0;
            ready_reg      <= 1'b0;
            icache_addr_o  <= '0;
            icache_wdata_o <= '0;
            reg_raddr_o    <= '0;
            dcache_raddr_o <= '0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            opc_reg      <= opc_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            chk_reg      <= chk_next;
            hold_reg     <= hold_next;
            ready_reg    <= (state_next inside {ST_IDLE, ST_HDR, ST_DATA, ST_CHK});
            // Target-facing outputs change only at EXEC entry so they are stable for the whole window.
            if (exec_enter) begin
                icache_addr_o  <= addr_next[IADDR_WIDTH-1:0];
                icache_wdata_o <= wdata_next;
                reg_raddr_o    <= addr_next[RADDR_WIDTH-1:0];
                dcache_raddr_o <= addr_next[DADDR_WIDTH-1:0];
            end
        end
    end

    dbg_rsp_ser u_rsp_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .word      (ser_word),
        .multi     (ser_multi),
        .rsp_ready (rsp_ready_i),
        .rsp_valid (rsp_valid_o),
        .rsp_data  (rsp_data_o),
        .done      (ser_done)
    );

endmodule

// File: tb/tb_debug_cmd_ctrl.sv
// Scoreboard bench for debug_cmd_ctrl with an io_control/SRAM model; directed cases then random commands.
module tb_debug_cmd_ctrl;

    localparam int HOLD = 3;

    typedef struct packed {
        logic [2:0]  code;
        logic [11:0] ia;
        logic [4:0]  ra;
        logic [11:0] da;
        logic [31:0] wd;
    } exec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_valid_i = 1'b0;
    logic [7:0]  host_data_i = 8'h00;
    logic        host_ready_o;
    logic        rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_ready_i = 1'b0;
    logic [2:0]  debug_o;
    logic [11:0] icache_addr_o;
    logic [31:0] icache_wdata_o;
    logic [4:0]  reg_raddr_o;
    logic [11:0] dcache_raddr_o;
    logic [11:0] pc_i = 12'h000;
    logic [31:0] icache_rdata_i = '0, reg_rdata_i = '0, dcache_rdata_i = '0;

    always #5 clk = ~clk;

    debug_cmd_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .host_valid_i(host_valid_i), .host_data_i(host_data_i), .host_ready_o(host_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready_i),
        .debug_o(debug_o), .icache_addr_o(icache_addr_o), .icache_wdata_o(icache_wdata_o),
        .reg_raddr_o(reg_raddr_o), .dcache_raddr_o(dcache_raddr_o),
        .pc_i(pc_i), .icache_rdata_i(icache_rdata_i), .reg_rdata_i(reg_rdata_i),
        .dcache_rdata_i(dcache_rdata_i)
    );

    // io_control model: registered result words, icache SRAM written through the debug port.
    logic [31:0] imem [4096];
    logic [31:0] ref_imem [4096];
    logic [31:0] rf [32];
    logic [31:0] dmem [4096];

    always @(posedge clk) begin
        if (debug_o == 3'd3) imem[icache_addr_o] <= icache_wdata_o;
        if (debug_o == 3'd2) icache_rdata_i <= imem[icache_addr_o];
        if (debug_o == 3'd4) reg_rdata_i <= rf[reg_raddr_o];
        if (debug_o == 3'd5) dcache_rdata_i <= dmem[dcache_raddr_o];
    end

    int checks = 0, failures = 0;
    int cyc = 0, acc_cyc = 0;
    bit stall_force = 1'b0;
    logic [7:0] exp_rsp[$], stg_rsp[$];
    exec_t      exp_exec[$], stg_exec[$];
    int         exp_lat[$], stg_lat[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        rsp_ready_i = stall_force ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: response bytes, stall stability, latency and EXEC window shape.
    logic       rsp_valid_d = 1'b0, stalled = 1'b0;
    logic [7:0] stall_data = 8'h00;
    int         exec_len = 0;
    exec_t      cur_exec = '0;

    always @(negedge clk) begin : mon
        int l;
        if (!rst_n) begin
            rsp_valid_d = 1'b0;
            stalled     = 1'b0;
            exec_len    = 0;
        end else begin
            if (rsp_valid_o && !rsp_valid_d) begin
                chk("rsp_start_expected", exp_lat.size() != 0, 1);
                if (exp_lat.size() != 0) begin
                    l = exp_lat.pop_front();
                    if (l >= 0) chk("latency", cyc - acc_cyc, l);
                end
            end
            if (stalled && rsp_valid_o) chk("stall_hold", rsp_data_o, stall_data);
            if (rsp_valid_o) begin
                if (rsp_ready_i) begin
                    chk("rsp_byte_expected", exp_rsp.size() != 0, 1);
                    if (exp_rsp.size() != 0) chk("rsp_byte", rsp_data_o, exp_rsp.pop_front());
                    chk("host_ready_in_resp", host_ready_o, 0);
                    stalled = 1'b0;
                end else begin
                    stalled    = 1'b1;
                    stall_data = rsp_data_o;
                end
            end else begin
                stalled = 1'b0;
            end
            rsp_valid_d = rsp_valid_o;

            if (debug_o != 3'd0) begin
                if (exec_len == 0) begin
                    chk("exec_expected", exp_exec.size() != 0, 1);
                    if (exp_exec.size() != 0) cur_exec = exp_exec.pop_front();
                    chk("exec_icache_addr", icache_addr_o, cur_exec.ia);
                    chk("exec_reg_raddr", reg_raddr_o, cur_exec.ra);
                    chk("exec_dcache_raddr", dcache_raddr_o, cur_exec.da);
                    if (cur_exec.code == 3'd3) chk("exec_wdata", icache_wdata_o, cur_exec.wd);
                    chk("host_ready_in_exec", host_ready_o, 0);
                end else begin
                    chk("exec_addr_stable", icache_addr_o, cur_exec.ia);
                end
                chk("exec_code", debug_o, cur_exec.code);
                exec_len++;
            end else if (exec_len != 0) begin
                chk("exec_len", exec_len, HOLD);
                exec_len = 0;
            end
        end
    end

    task automatic send_raw(input logic [7:0] b, input bit last);
        int n;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        host_valid_i = 1'b1;
        host_data_i  = b;
        n = 0;
        @(negedge clk);
        while (!host_ready_o && n < 200) begin @(negedge clk); n++; end
        chk("host_ready_wait", n < 200, 1);
        if (last) begin
            while (stg_rsp.size() != 0)  exp_rsp.push_back(stg_rsp.pop_front());
            while (stg_exec.size() != 0) exp_exec.push_back(stg_exec.pop_front());
            while (stg_lat.size() != 0)  exp_lat.push_back(stg_lat.pop_front());
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        host_valid_i = 1'b0;
    endtask

    // Reference model: expected exec window and response bytes derived from the frame contents.
    task automatic send_cmd(input logic [7:0] opc, input logic [15:0] addr,
                            input logic [31:0] data, input bit bad_chk);
        logic [7:0]  fr[$];
        logic [7:0]  x;
        logic [31:0] w;
        bit          ok;
        fr = '{opc, addr[7:0], addr[15:8]};
        if (opc == 8'h03) for (int i = 0; i < 4; i++) fr.push_back(data[8*i +: 8]);
        ok = (opc >= 8'h01 && opc <= 8'h05);
`ifdef DBG_CMD_CHECKSUM_EN
        x = 8'h00;
        foreach (fr[i]) x ^= fr[i];
        fr.push_back(bad_chk ? ~x : x);
        ok = ok && !bad_chk;
`else
        x = {7'h00, bad_chk};
`endif
        if (!ok) begin
            stg_rsp.push_back(8'hEE);
            stg_lat.push_back(-1);
        end else begin
            stg_exec.push_back('{code: opc[2:0], ia: addr[11:0], ra: addr[4:0], da: addr[11:0], wd: data});
            stg_lat.push_back(HOLD + 2);
            case (opc)
                8'h01: w = {20'h0, pc_i};
                8'h02: w = ref_imem[addr[11:0]];
                8'h04: w = rf[addr[4:0]];
                8'h05: w = dmem[addr[11:0]];
                default: begin
                    w = 32'h0;
                    ref_imem[addr[11:0]] = data;
                end
            endcase
            if (opc == 8'h03) stg_rsp.push_back(8'hA5);
            else for (int i = 0; i < 4; i++) stg_rsp.push_back(w[8*i +: 8]);
        end
`ifdef DBG_CMD_CHECKSUM_EN
        x = 8'h00;
        foreach (stg_rsp[i]) x ^= stg_rsp[i];
        stg_rsp.push_back(x);
`endif
        for (int i = 0; i < fr.size(); i++) send_raw(fr[i], i == fr.size() - 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || rsp_valid_o) && n < 500) begin @(negedge clk); n++; end
        chk("response_drained", n < 500, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_debug"}, debug_o, 0);
        chk({tag, "_icache_addr"}, icache_addr_o, 0);
        chk({tag, "_wdata"}, icache_wdata_o, 0);
        chk({tag, "_reg_raddr"}, reg_raddr_o, 0);
        chk({tag, "_dcache_raddr"}, dcache_raddr_o, 0);
        chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
        chk({tag, "_rsp_data"}, rsp_data_o, 0);
        chk({tag, "_host_ready"}, host_ready_o, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        logic [7:0] opc;
        for (int i = 0; i < 4096; i++) begin
            imem[i] = $urandom;
            ref_imem[i] = imem[i];
            dmem[i] = $urandom;
        end
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[5] = 32'h0000_0007;

        #22;
        chk_reset_outputs("por");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", host_ready_o, 1);

        send_cmd(8'h03, 16'h0012, 32'hDEAD_BEEF, 1'b0); wait_idle();
        send_cmd(8'h02, 16'h0012, 32'h0, 1'b0);         wait_idle();
        send_cmd(8'h04, 16'h0025, 32'h0, 1'b0);         wait_idle();
        send_cmd(8'h7F, 16'h0034, 32'h0, 1'b0);         wait_idle();
        pc_i = 12'h3C4;
        send_cmd(8'h01, 16'h0000, 32'h0, 1'b0);         wait_idle();

        // Host stalls the first response byte for 10 cycles.
        stall_force = 1'b1;
        send_cmd(8'h05, 16'h0123, 32'h0, 1'b0);
        r = 0;
        while (!rsp_valid_o && r < 100) begin @(negedge clk); r++; end
        chk("stall_rsp_seen", rsp_valid_o, 1);
        repeat (10) begin
            @(negedge clk);
            chk("stall_byte0", rsp_data_o, dmem[12'h123][7:0]);
            chk("stall_host_ready", host_ready_o, 0);
        end
        stall_force = 1'b0;
        wait_idle();

        // Reset while ICWR data byte 2 is on the bus.
        send_raw(8'h03, 1'b0); send_raw(8'h56, 1'b0); send_raw(8'h00, 1'b0);
        send_raw(8'h11, 1'b0); send_raw(8'h22, 1'b0);
        host_valid_i = 1'b1;
        host_data_i  = 8'h33;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midframe");
        host_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_midframe", host_ready_o, 1);
        pc_i = 12'h9A1;
        send_cmd(8'h01, 16'h0000, 32'h0, 1'b0); wait_idle();
        send_cmd(8'h02, 16'h0056, 32'h0, 1'b0); wait_idle();

`ifdef DBG_CMD_CHECKSUM_EN
        send_cmd(8'h02, 16'h0012, 32'h0, 1'b1); wait_idle();
`endif

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 5);
            opc = (r == 0) ? 8'($urandom_range(6, 255)) : 8'(r);
            pc_i = 12'($urandom);
            send_cmd(opc, 16'($urandom), $urandom, $urandom_range(0, 7) == 0);
            wait_idle();
        end

        repeat (5) @(posedge clk);
        chk("exec_queue_empty", exp_exec.size(), 0);
        chk("lat_queue_empty", exp_lat.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
